// File: rtl/mem_seq_pkg.sv
// Shared constants for the byte-serial memory command front-end:
// FSM state encoding, opcode bit positions and the byte width.
package mem_seq_pkg;

  localparam int BYTE_W    = 8;
  localparam int OP_W      = 7;
  localparam int OP_P      = 6;
  localparam int OP_RSV_HI = 5;
  localparam int OP_RSV_LO = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_HI   = 3'd1,
    S_WR_LO   = 3'd2,
    S_WR_EXEC = 3'd3,
    S_RD_EXEC = 3'd4,
    S_RD_WAIT = 3'd5,
    S_RSP_HI  = 3'd6,
    S_RSP_LO  = 3'd7
  } state_t;

endpackage

// File: rtl/mem_rsp_ser.sv
// Response serializer: loads one DW-bit word and emits it high byte first on a
// valid/ready stream, holding each byte until it is taken.
module mem_rsp_ser
  import mem_seq_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DW-1:0]     word,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready
);

  logic [BYTE_W-1:0] lo_q;
  logic              lo_phase;

  // A byte moves when rsp_valid && rsp_ready at a rising edge; until then
  // rsp_valid and rsp_data are held unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      lo_q      <= '0;
      lo_phase  <= 1'b0;
    end else if (load) begin
      rsp_data  <= word[DW-1:BYTE_W];
      lo_q      <= word[BYTE_W-1:0];
      rsp_valid <= 1'b1;
      lo_phase  <= 1'b0;
    end else if (rsp_valid && rsp_ready) begin
      if (!lo_phase) begin
        rsp_data <= lo_q;
        lo_phase <= 1'b1;
      end else begin
        rsp_valid <= 1'b0;
        lo_phase  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_cmd_seq.sv
// Byte-serial command front-end for the DFF word memory. Optional pointer
// addressing is enabled by defining MEM_CMD_SEQ_AUTOINC_EN.
module mem_cmd_seq
  import mem_seq_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout,
  output logic              busy,
  output logic              err
);

  if (DW != 2*BYTE_W) begin : g_dw_check
    $error("mem_cmd_seq: DW must equal 2*BYTE_W (16)");
  end

  state_t            state, state_nxt;
  logic              cmd_fire, rsp_fire, op_bad;
  logic [AW-1:0]     op_addr, addr_q;
  logic [BYTE_W-1:0] hi_q;
  logic [DW-1:0]     rd_word;
  logic              rsp_load;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign op_bad   = |cmd_data[OP_RSV_HI:OP_RSV_LO];

`ifdef MEM_CMD_SEQ_AUTOINC_EN
  logic [AW-1:0] ptr;

  assign op_addr = cmd_data[OP_P] ? ptr : AW'(cmd_data[3:0]);

  // The pointer advances past the address of each access as the access is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state == S_IDLE && cmd_fire && !op_bad && !cmd_data[OP_W]) begin
      ptr <= op_addr + AW'(1);
    end else if (state == S_WR_LO && cmd_fire) begin
      ptr <= addr_q + AW'(1);
    end
  end
`else
  logic unused_p;
  assign unused_p = cmd_data[OP_P];
  assign op_addr  = AW'(cmd_data[3:0]);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_fire && !op_bad) state_nxt = cmd_data[OP_W] ? S_WR_HI : S_RD_EXEC;
      S_WR_HI:   if (cmd_fire) state_nxt = S_WR_LO;
      S_WR_LO:   if (cmd_fire) state_nxt = S_WR_EXEC;
      S_WR_EXEC: state_nxt = S_IDLE;
      S_RD_EXEC: state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_RSP_HI;
      S_RSP_HI:  if (rsp_fire) state_nxt = S_RSP_LO;
      S_RSP_LO:  if (rsp_fire) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Status and memory strobes are registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      rd_word   <= '0;
      rsp_load  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == S_IDLE) || (state_nxt == S_WR_HI) || (state_nxt == S_WR_LO);
      busy      <= (state_nxt != S_IDLE);
      mem_cs    <= (state_nxt == S_WR_EXEC) || (state_nxt == S_RD_EXEC);
      mem_we    <= (state_nxt == S_WR_EXEC);
      rsp_load  <= (state == S_RD_WAIT);
      if (state == S_IDLE && cmd_fire) begin
        if (op_bad) begin
          err <= 1'b1;
        end else begin
          addr_q <= op_addr;
          if (!cmd_data[OP_W]) mem_addr <= op_addr;
        end
      end
      if (state == S_WR_HI && cmd_fire) hi_q <= cmd_data;
      // Address and data only change as the write is issued, so a write aborted
      // by reset never disturbs the memory port.
      if (state == S_WR_LO && cmd_fire) begin
        mem_addr <= addr_q;
        mem_din  <= {hi_q, cmd_data};
      end
      if (state == S_RD_WAIT) rd_word <= mem_dout;
    end
  end

  mem_rsp_ser #(.DW(DW)) u_rsp_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rsp_load),
    .word      (rd_word),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready)
  );

endmodule

// File: tb/tb_mem_cmd_seq.sv
// Self-checking bench for mem_cmd_seq: directed scenarios plus randomized command
// traffic scored against a word-level memory model. Honours MEM_CMD_SEQ_AUTOINC_EN.
module tb_mem_cmd_seq;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        mem_cs;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        busy;
  logic        err;

  mem_cmd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model and scoreboard ----------------
  logic [15:0] ref_mem [16];
  logic [15:0] env_mem [16];
  logic        mem_preload;
  logic        model_err;
  logic        hold_ready;
`ifdef MEM_CMD_SEQ_AUTOINC_EN
  logic [3:0]  ref_ptr;
`endif

  logic [7:0]  exp_rsp_q[$];
  logic [19:0] exp_wr_q[$];
  logic [3:0]  exp_rd_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_addr(input logic [7:0] op, output logic [3:0] a);
`ifdef MEM_CMD_SEQ_AUTOINC_EN
    a = op[6] ? ref_ptr : op[3:0];
    ref_ptr = a + 4'd1;
`else
    a = op[3:0];
`endif
  endtask

  // Word memory the DUT drives: write on cs&we, registered read data on cs&!we.
  always @(posedge clk) begin
    if (mem_preload) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= ref_mem[i];
    end else if (mem_cs) begin
      if (mem_we) env_mem[mem_addr] <= mem_din;
      else        mem_dout <= env_mem[mem_addr];
    end
  end

  // Consumer: random back-pressure unless a test forces it low.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every memory access and response byte must match the expected queues.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("rsp_hold", 32'({rsp_valid, rsp_data}), 32'({1'b1, prev_data}));
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", 32'(exp_rsp_q.size()), 1);
        else check("rsp_byte", 32'(rsp_data), 32'(exp_rsp_q.pop_front()));
      end
      if (mem_cs && mem_we) begin
        if (exp_wr_q.size() == 0) check("we_unexpected", 32'(exp_wr_q.size()), 1);
        else check("wr_access", 32'({mem_addr, mem_din}), 32'(exp_wr_q.pop_front()));
      end
      if (mem_cs && !mem_we) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(exp_rd_q.size()), 1);
        else check("rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   n;
    for (int i = 0; i < gap; i++) begin
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    cmd_data  = b;
    cmd_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("cmd_accept", 32'(acc), 1);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic cmd_write(input logic [7:0] op, input logic [15:0] d, input int gap);
    logic [3:0] a;
    model_addr(op, a);
    exp_wr_q.push_back({a, d});
    ref_mem[a] = d;
    send_byte(op, gap);
    send_byte(d[15:8], gap);
    send_byte(d[7:0], gap);
  endtask

  task automatic cmd_read(input logic [7:0] op, input int gap);
    logic [3:0]  a;
    logic [15:0] w;
    model_addr(op, a);
    w = ref_mem[a];
    exp_rd_q.push_back(a);
    exp_rsp_q.push_back(w[15:8]);
    exp_rsp_q.push_back(w[7:0]);
    send_byte(op, gap);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_rsp_q.size() != 0) && n < 300);
    check("drain_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  op;
    logic [15:0] d;
    int          g;
    int          n;

    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = 8'h00;
    hold_ready  = 1'b0;
    model_err   = 1'b0;
    mem_preload = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'($urandom);
`ifdef MEM_CMD_SEQ_AUTOINC_EN
    ref_ptr = 4'd0;
`endif

    // Reset values
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy",      32'(busy), 0);
    check("rst_err",       32'(err), 0);
    check("rst_mem_cs",    32'(mem_cs), 0);
    check("rst_mem_we",    32'(mem_we), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data",  32'(rsp_data), 0);
    check("rst_mem_addr",  32'(mem_addr), 0);
    check("rst_mem_din",   32'(mem_din), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_preload = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write 0xBEEF to addr 3, then read it back
    cmd_write(8'h83, 16'hBEEF, 0);
    @(negedge clk);
    check("wr_latency", 32'({mem_cs, mem_we}), 32'(2'b11));
    check("wr_addr", 32'(mem_addr), 3);
    check("wr_din",  32'(mem_din), 32'h0000_BEEF);
    @(posedge clk);
    #1;
    cmd_read(8'h03, 0);
    wait_idle();
    check("idle_after_read", 32'(busy), 0);

    // Back-pressure on the response stream
    hold_ready = 1'b1;
    cmd_read(8'h03, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("rd_latency", 32'(n - 1), 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_data",  32'(rsp_data), 32'h0000_00BE);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_cmd_ready", 32'(cmd_ready), 0);
    end
    hold_ready = 1'b0;
    wait_idle();

    // Bad opcode: consumed, flags err, no memory access
    send_byte(8'h90, 0);
    model_err = 1'b1;
    @(negedge clk);
    check("bad_err",       32'(err), 1);
    check("bad_busy",      32'(busy), 0);
    check("bad_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_read(8'h03, 0);
    wait_idle();

    // Reset in the middle of a write
    send_byte(8'h85, 0);
    send_byte(8'h12, 0);
    rst_n = 1'b0;
    model_err = 1'b0;
`ifdef MEM_CMD_SEQ_AUTOINC_EN
    ref_ptr = 4'd0;
`endif
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", 32'(cmd_ready), 1);
    check("midrst_err",       32'(err), 0);
    @(posedge clk);
    #1;
    cmd_read(8'h05, 0);
    wait_idle();

    // Gapped command stream
    cmd_write(8'h8A, 16'h1234, 1);
    wait_idle();
    cmd_read(8'h0A, 1);
    wait_idle();

    // Pointer wrap / direct addr 0
    cmd_write(8'h8F, 16'hA5A5, 0);
    cmd_write(8'hC0, 16'h0001, 0);
    @(negedge clk);
    check("autoinc_addr", 32'(mem_addr), 0);
    check("autoinc_din",  32'(mem_din), 1);
    @(posedge clk);
    #1;
    cmd_read(8'h00, 0);
    wait_idle();

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      op = 8'($urandom);
      op[5:4] = 2'b00;
      g = $urandom_range(0, 2);
      if ($urandom_range(0, 11) == 0) begin
        op[5:4] = 2'($urandom_range(1, 3));
        send_byte(op, g);
        model_err = 1'b1;
      end else if (op[7]) begin
        d = 16'($urandom);
        cmd_write(op, d, g);
      end else begin
        cmd_read(op, g);
      end
    end
    wait_idle();

    check("final_err",    32'(err), 32'(model_err));
    check("final_rsp_q",  32'(exp_rsp_q.size()), 0);
    check("final_wr_q",   32'(exp_wr_q.size()), 0);
    check("final_rd_q",   32'(exp_rd_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
